pixel_unswap_emitter: RTL

//  Output stage of the line-drawing core. Takes Bresenham pixels produced in steep-swapped

---
 rtl/pixel_unswap_emitter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pixel_unswap_emitter.sv
// rtl/pixel_unswap_emitter.sv - unswap steep Bresenham pixels, clip to screen, 2-entry skid buffer
`timescale 1ns/1ps
module pixel_unswap_emitter #(
    parameter int WIDTH    = 13,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_start,
    input  logic             steep_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             out_last,
    output logic             line_done,
    output logic             busy,
    output logic [CNT_W-1:0] pix_count,
    output logic [CNT_W-1:0] clip_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    localparam logic signed [WIDTH-1:0] MAX_X = WIDTH'(SCREEN_W);
    localparam logic signed [WIDTH-1:0] MAX_Y = WIDTH'(SCREEN_H);

    state_t state, state_next;
    logic   steep_q;

    logic [WIDTH-1:0] buf_x [2];
    logic [WIDTH-1:0] buf_y [2];
    logic             buf_last [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;

    logic signed [WIDTH-1:0] ux, uy;
    logic on_screen, accept, push, pop;

    // Undo the steep swap and decide whether the pixel lands on screen
    always_comb begin
        ux        = steep_q ? $signed(in_y) : $signed(in_x);
        uy        = steep_q ? $signed(in_x) : $signed(in_y);
        on_screen = !ux[WIDTH-1] && (ux < MAX_X) && !uy[WIDTH-1] && (uy < MAX_Y);
        accept    = in_valid && in_ready;
        push      = accept && on_screen;
        pop       = out_valid && out_ready;
    end

    // State register; steep flag is latched only when a line actually starts
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            steep_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && line_start)
                steep_q <= steep_in;
        end
    end

    // Next-state: start on line_start, drain after the last pixel, finish when empty
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (line_start) state_next = ACTIVE;
            ACTIVE:  if (accept && in_last) state_next = DRAIN;
            DRAIN:   if (count == 2'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so in_ready never sees out_ready
    always_comb begin
        in_ready  = (state == ACTIVE) && (count < 2'd2);
        busy      = (state != IDLE);
        line_done = (state == DRAIN) && (count == 2'd0);
    end

    // Two-entry FIFO; simultaneous push and pop keep the occupancy unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            buf_x[0]    <= '0;
            buf_x[1]    <= '0;
            buf_y[0]    <= '0;
            buf_y[1]    <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
        end else begin
            if (push) begin
                buf_x[wr_ptr]    <= ux;
                buf_y[wr_ptr]    <= uy;
                buf_last[wr_ptr] <= in_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_x     = buf_x[rd_ptr];
    assign out_y     = buf_y[rd_ptr];
    assign out_last  = buf_last[rd_ptr];

    // Per-line statistics, cleared on line start and held through IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count  <= '0;
            clip_count <= '0;
        end else if (state == IDLE && line_start) begin
            pix_count  <= '0;
            clip_count <= '0;
        end else begin
            if (pop && pix_count != '1)
                pix_count <= pix_count + CNT_W'(1);
            if (accept && !on_screen && clip_count != '1)
                clip_count <= clip_count + CNT_W'(1);
        end
    end

endmodule
